// File: rtl/uart_tx_serializer_if.sv
// Byte handshake between the command/response logic and the UART transmitter:
// valid/ready for one byte plus the end-of-frame pulse.
interface uart_tx_serializer_if;
  logic [7:0] data_in;
  logic       send;
  logic       ready;
  logic       done;

  modport master (
    output data_in,
    output send,
    input  ready,
    input  done
  );

  modport slave (
    input  data_in,
    input  send,
    output ready,
    output done
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter with single-byte valid/ready handshake, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frame).
module uart_tx_serializer #(
  parameter int CLOCK_FREQ   = 50_000_000,
  parameter int BAUD_RATE    = 9600,
  parameter int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE
) (
  input  logic                 clock,
  input  logic                 reset_n,
  uart_tx_serializer_if.slave  bus,
  output logic                 tx
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  function automatic logic even_parity(input logic [7:0] data);
    even_parity = ^data;
  endfunction
`else
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd4
  } state_t;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             baud_end;
`ifdef UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  assign baud_end  = (baud_q == BAUD_LAST);
  assign tx        = tx_q;
  assign bus.ready = ready_q;
  assign bus.done  = done_q;

  // Each branch computes the value tx must hold for the next cycle so that
  // tx changes exactly on the bit-boundary edge.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    ready_d   = ready_q;
    done_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        baud_d    = {CNT_W{1'b0}};
        bit_idx_d = 3'd0;
        if (bus.send) begin
          shift_d = bus.data_in;
`ifdef UART_TX_PARITY_EN
          parity_d = even_parity(bus.data_in);
`endif
          state_d = ST_START;
          tx_d    = 1'b0;
          ready_d = 1'b0;
        end else begin
          tx_d    = 1'b1;
          ready_d = 1'b1;
        end
      end
      ST_START: begin
        if (baud_end) begin
          baud_d  = {CNT_W{1'b0}};
          state_d = ST_DATA;
          tx_d    = shift_q[0];
        end else begin
          baud_d  = baud_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (baud_end) begin
          baud_d  = {CNT_W{1'b0}};
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = 3'd0;
`ifdef UART_TX_PARITY_EN
            state_d   = ST_PARITY;
            tx_d      = parity_q;
`else
            state_d   = ST_STOP;
            tx_d      = 1'b1;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[1];
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_end) begin
          baud_d  = {CNT_W{1'b0}};
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end else begin
          baud_d  = baud_q + CNT_W'(1);
        end
      end
`endif
      ST_STOP: begin
        // ready rises together with done so a waiting send starts next edge
        if (baud_end) begin
          baud_d  = {CNT_W{1'b0}};
          state_d = ST_IDLE;
          tx_d    = 1'b1;
          ready_d = 1'b1;
          done_d  = 1'b1;
        end else begin
          baud_d  = baud_q + CNT_W'(1);
        end
      end
      default: begin
        state_d   = ST_IDLE;
        baud_d    = {CNT_W{1'b0}};
        bit_idx_d = 3'd0;
        tx_d      = 1'b1;
        ready_d   = 1'b1;
      end
    endcase
  end

  // State and output registers; synchronous active-low reset aborts any frame.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      baud_q    <= {CNT_W{1'b0}};
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      tx_q      <= 1'b1;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench: fast instance (4 clocks/bit) with a bench UART receiver
// feeding a scoreboard, plus a default-rate instance for bit-period timing.
module tb_uart_tx_serializer;

  localparam int CPB     = 4;
  localparam int DEF_CPB = 5208;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = FRAME_BITS * CPB;

  logic clock;
  logic reset_n;
  logic tx_fast;
  logic tx_def;

  uart_tx_serializer_if bus_fast ();
  uart_tx_serializer_if bus_def ();

  uart_tx_serializer #(.CLKS_PER_BIT(CPB)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_fast),
    .tx      (tx_fast)
  );

  uart_tx_serializer dut_def (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_def),
    .tx      (tx_def)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // {stop_ok, parity_ok, byte}
  logic [9:0] exp_q[$];
  logic [9:0] got_q[$];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_done(input int max_cyc, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      tick();
      if (bus_fast.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  // Bench UART receiver: samples mid-bit and pushes each decoded frame.
  initial begin : rx_model
    logic [7:0] b;
    logic       par_ok;
    logic       stop_ok;
    forever begin
      @(posedge clock);
      #1;
      if (tx_fast === 1'b0) begin
        repeat (CPB / 2) begin @(posedge clock); #1; end
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) begin @(posedge clock); #1; end
          b[i] = tx_fast;
        end
        par_ok = 1'b1;
`ifdef UART_TX_PARITY_EN
        repeat (CPB) begin @(posedge clock); #1; end
        par_ok = (tx_fast === ^b);
`endif
        repeat (CPB) begin @(posedge clock); #1; end
        stop_ok = (tx_fast === 1'b1);
        got_q.push_back({stop_ok, par_ok, b});
      end
    end
  end

  task automatic test_reset();
    reset_n = 1'b0;
    bus_fast.send = 1'b1;
    bus_fast.data_in = 8'h50;
    bus_def.send = 1'b0;
    bus_def.data_in = 8'h00;
    repeat (3) tick();
    n_tests++;
    if (tx_fast !== 1'b1 || bus_fast.ready !== 1'b1 || bus_fast.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: tx=%b ready=%b done=%b, required tx=1 ready=1 done=0",
               tx_fast, bus_fast.ready, bus_fast.done);
    end
    n_tests++;
    if (tx_def !== 1'b1 || bus_def.ready !== 1'b1 || bus_def.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state_def: tx=%b ready=%b done=%b, required 1 1 0",
               tx_def, bus_def.ready, bus_def.done);
    end
    bus_fast.send = 1'b0;
    reset_n = 1'b1;
    repeat (2) tick();
    n_tests++;
    if (tx_fast !== 1'b1 || bus_fast.ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_no_frame: tx=%b ready=%b, required tx=1 ready=1",
               tx_fast, bus_fast.ready);
    end
  endtask

  task automatic test_single();
`ifdef UART_TX_PARITY_EN
    logic exp_bits [FRAME_BITS] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
`else
    logic exp_bits [FRAME_BITS] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
`endif
    bus_fast.data_in = 8'h31;
    bus_fast.send = 1'b1;
    exp_q.push_back({2'b11, 8'h31});
    tick();
    bus_fast.send = 1'b0;
    for (int c = 0; c < FRAME_CYC; c++) begin
      n_tests++;
      if (tx_fast !== exp_bits[c / CPB] || bus_fast.done !== 1'b0 || bus_fast.ready !== 1'b0) begin
        n_fail++;
        $display("FAIL single_seq cycle %0d: tx=%b done=%b ready=%b, required tx=%b done=0 ready=0",
                 c, tx_fast, bus_fast.done, bus_fast.ready, exp_bits[c / CPB]);
      end
      tick();
    end
    n_tests++;
    if (bus_fast.done !== 1'b1 || bus_fast.ready !== 1'b1 || tx_fast !== 1'b1) begin
      n_fail++;
      $display("FAIL single_done at cycle %0d: done=%b ready=%b tx=%b, required 1 1 1",
               FRAME_CYC, bus_fast.done, bus_fast.ready, tx_fast);
    end
    tick();
    n_tests++;
    if (bus_fast.done !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done_pulse: done=%b one cycle later, required 0", bus_fast.done);
    end
    n_tests++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL single_count: received %0d frames, required %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [9:0] g, e;
      g = got_q.pop_front();
      e = exp_q.pop_front();
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL single_rx: got %h, required %h", g, e);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    bit seen;
    bus_fast.data_in = 8'h50;
    bus_fast.send = 1'b1;
    exp_q.push_back({2'b11, 8'h50});
    exp_q.push_back({2'b11, 8'h31});
    tick();
    bus_fast.data_in = 8'h31;
    wait_done(FRAME_CYC + 8, seen);
    n_tests++;
    if (seen !== 1'b1 || bus_fast.ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first_done: seen=%b ready=%b, required 1 1", seen, bus_fast.ready);
    end
    tick();
    n_tests++;
    if (tx_fast !== 1'b0 || bus_fast.ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second_start: tx=%b ready=%b, required tx=0 ready=0",
               tx_fast, bus_fast.ready);
    end
    bus_fast.send = 1'b0;
    wait_done(FRAME_CYC + 8, seen);
    n_tests++;
    if (seen !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second_done: done not seen within %0d cycles", FRAME_CYC + 8);
    end
    repeat (2) tick();
    n_tests++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL b2b_count: received %0d frames, required %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [9:0] g, e;
      g = got_q.pop_front();
      e = exp_q.pop_front();
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL b2b_rx: got %h, required %h", g, e);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_busy_ignore();
    bit seen;
    int low_cnt;
    bus_fast.data_in = 8'h31;
    bus_fast.send = 1'b1;
    exp_q.push_back({2'b11, 8'h31});
    tick();
    bus_fast.send = 1'b0;
    repeat (10) tick();
    bus_fast.data_in = 8'hFF;
    bus_fast.send = 1'b1;
    tick();
    bus_fast.send = 1'b0;
    bus_fast.data_in = 8'h00;
    wait_done(FRAME_CYC + 8, seen);
    n_tests++;
    if (seen !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_done: done not seen within %0d cycles", FRAME_CYC + 8);
    end
    low_cnt = 0;
    for (int i = 0; i < 2 * FRAME_CYC; i++) begin
      tick();
      if (tx_fast !== 1'b1 || bus_fast.ready !== 1'b1) low_cnt++;
    end
    n_tests++;
    if (low_cnt !== 0) begin
      n_fail++;
      $display("FAIL busy_no_second_frame: %0d busy/low cycles after done, required 0", low_cnt);
    end
    n_tests++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL busy_count: received %0d frames, required %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [9:0] g, e;
      g = got_q.pop_front();
      e = exp_q.pop_front();
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL busy_rx: got %h, required %h", g, e);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_mid_frame();
    bit seen;
    int done_cnt;
    bus_fast.data_in = 8'h31;
    bus_fast.send = 1'b1;
    tick();
    bus_fast.send = 1'b0;
    repeat (14) tick();
    reset_n = 1'b0;
    tick();
    n_tests++;
    if (tx_fast !== 1'b1 || bus_fast.done !== 1'b0 || bus_fast.ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_abort: tx=%b done=%b ready=%b, required 1 0 1",
               tx_fast, bus_fast.done, bus_fast.ready);
    end
    tick();
    reset_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < FRAME_CYC + 5; i++) begin
      tick();
      if (bus_fast.done !== 1'b0 || tx_fast !== 1'b1) done_cnt++;
    end
    n_tests++;
    if (done_cnt !== 0) begin
      n_fail++;
      $display("FAIL rst_mid_no_done: %0d cycles with done or line activity, required 0", done_cnt);
    end
    got_q.delete();
    bus_fast.data_in = 8'h50;
    bus_fast.send = 1'b1;
    exp_q.push_back({2'b11, 8'h50});
    tick();
    bus_fast.send = 1'b0;
    wait_done(FRAME_CYC + 8, seen);
    n_tests++;
    if (seen !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_resend_done: done not seen within %0d cycles", FRAME_CYC + 8);
    end
    tick();
    n_tests++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL rst_mid_count: received %0d frames, required %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [9:0] g, e;
      g = got_q.pop_front();
      e = exp_q.pop_front();
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL rst_mid_rx: got %h, required %h", g, e);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_default_rate();
    int lo, hi, total;
    // 8'h50 LSB first: start + four 0 data bits, then a single 1 bit
    bus_def.data_in = 8'h50;
    bus_def.send = 1'b1;
    tick();
    bus_def.send = 1'b0;
    lo = 0;
    while (tx_def === 1'b0 && lo < DEF_CPB * 6) begin
      tick();
      lo++;
    end
    hi = 0;
    while (tx_def === 1'b1 && hi < DEF_CPB * 2) begin
      tick();
      hi++;
    end
    total = lo + hi;
    while (bus_def.done !== 1'b1 && total < DEF_CPB * 12) begin
      tick();
      total++;
    end
    n_tests++;
    if (lo !== 5 * DEF_CPB) begin
      n_fail++;
      $display("FAIL def_low_run: %0d cycles, required %0d", lo, 5 * DEF_CPB);
    end
    n_tests++;
    if (hi !== DEF_CPB) begin
      n_fail++;
      $display("FAIL def_bit_period: %0d cycles, required %0d", hi, DEF_CPB);
    end
    n_tests++;
    if (total !== FRAME_BITS * DEF_CPB) begin
      n_fail++;
      $display("FAIL def_frame_len: %0d cycles, required %0d", total, FRAME_BITS * DEF_CPB);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    bus_fast.send = 1'b0;
    bus_fast.data_in = 8'h00;
    bus_def.send = 1'b0;
    bus_def.data_in = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid_frame();
    test_default_rate();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
